// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage RV32I pipeline: stage enables, flushes, mem wait, halt drain.
// Define HAZARD_PERF_EN to add the saturating stall_cnt/flush_cnt performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_hlt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             pc_redirect,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic             mem_timeout_err,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic [2:0]       state
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALTED   = 3'd3
  } state_t;

  state_t        state_q, state_d, ret_q, ret_d, mode;
  logic [WW-1:0] wait_q, wait_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          halted_q, halted_d;
  logic          err_q, err_d;
  logic          mem_stall, load_use;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));

  always_comb begin
    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
    {pc_redirect, ifid_flush, idex_flush}         = '0;
    state_d  = state_q;
    ret_d    = ret_q;
    wait_d   = wait_q;
    drain_d  = drain_q;
    halted_d = halted_q;
    err_d    = err_q;
    // A completing access in MEM_WAIT runs the origin state's logic this cycle,
    // so a held redirect/hazard/halt is acted on exactly once.
    mode = state_q;
    if (state_q == MEM_WAIT && mem_ready) mode = ret_q;

    case (mode)
      RUN: begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
        state_d = RUN;
        if (mem_stall) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
          state_d = MEM_WAIT;
          ret_d   = RUN;
          wait_d  = WW'(1);
        end else if (ex_redirect) begin
          {pc_redirect, ifid_flush, idex_flush} = '1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (id_hlt) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          state_d    = DRAIN;
          drain_d    = '0;
        end
      end
      DRAIN: begin
        state_d = DRAIN;
        if (mem_stall) begin
          state_d = MEM_WAIT;
          ret_d   = DRAIN;
          wait_d  = WW'(1);
        end else if (ex_redirect) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
          {pc_redirect, ifid_flush, idex_flush}         = '1;
          state_d = RUN;
        end else begin
          {ifid_en, idex_en, exmem_en, memwb_en} = '1;
          ifid_flush = 1'b1;
          drain_d    = drain_q + DW'(1);
          if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        if (wait_q == WW'(MEM_TIMEOUT)) begin
          err_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = HALTED;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      HALTED: begin
        halted_d = 1'b1;
        if (resume) begin
          halted_d = 1'b0;
          state_d  = RUN;
        end
      end
      default: begin
        state_d  = RUN;
        halted_d = 1'b0;
      end
    endcase

    if (!rst_n) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      pc_redirect = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      ret_q    <= RUN;
      wait_q   <= '0;
      drain_q  <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      wait_q   <= wait_d;
      drain_q  <= drain_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign state           = state_q;
  assign halted          = halted_q;
  assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_evt;

  // A load-use bubble is the only case flushing ID/EX without flushing IF/ID.
  assign stall_evt = (idex_flush & ~ifid_flush) | (state_q == MEM_WAIT);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state_q != HALTED) begin
      if (stall_evt && stall_cnt_q != '1)   stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (pc_redirect && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl (DRAIN_CYCLES=3, MEM_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, id_hlt, ex_mem_read, ex_redirect;
  logic       mem_req, mem_ready, resume;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       pc_redirect, ifid_flush, idex_flush, halted, mem_timeout_err;
  logic [2:0] state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(8), .CNT_W(16)) dut (
    .CLOCK_50(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_hlt(id_hlt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .resume(resume),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .pc_redirect(pc_redirect), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .mem_timeout_err(mem_timeout_err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // en = {pc,ifid,idex,exmem,memwb}, fl = {pc_redirect,ifid_flush,idex_flush}
  task automatic check_ctl(input string tag, input logic [4:0] en, input logic [2:0] fl,
                           input logic [2:0] st);
    check({tag, ".en"}, {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, en});
    check({tag, ".fl"}, {29'd0, pc_redirect, ifid_flush, idex_flush}, {29'd0, fl});
    check({tag, ".st"}, {29'd0, state}, {29'd0, st});
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_hlt = 0; ex_mem_read = 0; ex_redirect = 0;
    mem_req = 0; mem_ready = 0; resume = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    check_ctl("reset", 5'b00000, 3'b011, 3'd0);
    check("reset.halted", {31'd0, halted}, 32'd0);
    check("reset.err", {31'd0, mem_timeout_err}, 32'd0);

    step(); rst_n = 1'b1; #1;
    check_ctl("run_default", 5'b11111, 3'b000, 3'd0);

    // load-use on rs2
    ex_mem_read = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1; #1;
    check_ctl("loaduse", 5'b00111, 3'b001, 3'd0);
    step(); idle(); #1;
    check_ctl("loaduse_after", 5'b11111, 3'b000, 3'd0);

    // x0 destination and unused operand never stall
    ex_mem_read = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1; #1;
    check_ctl("rd_zero", 5'b11111, 3'b000, 3'd0);
    ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 0; #1;
    check_ctl("rs1_unused", 5'b11111, 3'b000, 3'd0);
    step(); idle();

    // redirect wins over simultaneous load-use
    ex_mem_read = 1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1; ex_redirect = 1; #1;
    check_ctl("redir_vs_lu", 5'b11111, 3'b111, 3'd0);
    step(); idle(); #1;
    check_ctl("redir_after", 5'b11111, 3'b000, 3'd0);

    // 4 cycles of memory wait, ready on the 5th
    mem_req = 1; mem_ready = 0; #1;
    check_ctl("mw_entry", 5'b00000, 3'b000, 3'd0);
    for (int unsigned i = 1; i < 4; i++) begin
      step(); #1;
      check_ctl($sformatf("mw_wait%0d", i), 5'b00000, 3'b000, 3'd1);
    end
    step(); mem_ready = 1; #1;
    check_ctl("mw_ready", 5'b11111, 3'b000, 3'd1);
    step(); idle(); #1;
    check_ctl("mw_back", 5'b11111, 3'b000, 3'd0);

    // timeout after 8 wait cycles
    mem_req = 1; mem_ready = 0;
    for (int unsigned i = 1; i <= 8; i++) begin
      step(); #1;
      check($sformatf("to_wait%0d.st", i), {29'd0, state}, 32'd1);
    end
    check("to_pre.err", {31'd0, mem_timeout_err}, 32'd0);
    step(); idle(); #1;
    check_ctl("to_halted", 5'b00000, 3'b000, 3'd3);
    check("to.halted", {31'd0, halted}, 32'd1);
    check("to.err", {31'd0, mem_timeout_err}, 32'd1);
    step(); #1;
    check("to_hold.st", {29'd0, state}, 32'd3);
    resume = 1; step(); resume = 0; #1;
    check_ctl("to_resume", 5'b11111, 3'b000, 3'd0);
    check("to_resume.halted", {31'd0, halted}, 32'd0);
    check("to_resume.err", {31'd0, mem_timeout_err}, 32'd1);

    // halt: 3 drain cycles then halted
    id_hlt = 1; #1;
    check_ctl("hlt_accept", 5'b01111, 3'b010, 3'd0);
    step(); idle();
    for (int unsigned i = 1; i <= 3; i++) begin
      #1;
      check_ctl($sformatf("drain%0d", i), 5'b01111, 3'b010, 3'd2);
      check($sformatf("drain%0d.halted", i), {31'd0, halted}, 32'd0);
      step();
    end
    #1;
    check_ctl("drain_done", 5'b00000, 3'b000, 3'd3);
    check("drain_done.halted", {31'd0, halted}, 32'd1);
    resume = 1; step(); resume = 0; #1;
    check("drain_resume.st", {29'd0, state}, 32'd0);

    // wrong-path halt cancelled by redirect in drain cycle 2
    id_hlt = 1; step(); idle(); #1;
    check("cancel_d1.st", {29'd0, state}, 32'd2);
    step(); ex_redirect = 1; #1;
    check_ctl("cancel_d2", 5'b11111, 3'b111, 3'd2);
    step(); idle(); #1;
    check_ctl("cancel_run", 5'b11111, 3'b000, 3'd0);
    check("cancel.halted", {31'd0, halted}, 32'd0);
    step(); #1;
    check("cancel_stay.st", {29'd0, state}, 32'd0);

    // memory stall inside drain freezes the drain count
    id_hlt = 1; step(); idle();
    mem_req = 1; #1;
    check_ctl("dmw_entry", 5'b00000, 3'b000, 3'd2);
    step(); mem_ready = 1; #1;
    check_ctl("dmw_ready", 5'b01111, 3'b010, 3'd1);
    step(); idle(); #1;
    check_ctl("dmw_d2", 5'b01111, 3'b010, 3'd2);
    step(); #1;
    check("dmw_d3.st", {29'd0, state}, 32'd2);
    step(); #1;
    check("dmw_halt.st", {29'd0, state}, 32'd3);
    resume = 1; step(); resume = 0; #1;
    check("dmw_resume.st", {29'd0, state}, 32'd0);

    // asynchronous reset in the middle of MEM_WAIT
    mem_req = 1; mem_ready = 0;
    step(); step(); #2;
    check("rst_mid_pre.st", {29'd0, state}, 32'd1);
    rst_n = 1'b0; #1;
    check_ctl("rst_mid", 5'b00000, 3'b011, 3'd0);
    step(); idle(); rst_n = 1'b1; #1;
    check_ctl("rst_release", 5'b11111, 3'b000, 3'd0);
    check("rst_release.err", {31'd0, mem_timeout_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
